// File: rtl/ball_multi_draw.sv
// Multi-ball sprite drawer: NUM_BALLS 32x32 balls from one shared 2-bit bitmap,
// each with its own body colour, visibility and frame-timed sink-into-pocket shrink.
module ball_multi_draw #(
   parameter int unsigned          NUM_BALLS            = 2,
   parameter int unsigned          SINK_RATE            = 2,
   parameter logic [NUM_BALLS-1:0] INIT_VISIBLE         = '1,
   parameter logic [7:0]           TRANSPARENT_ENCODING = 8'hFF,
   localparam int unsigned         IDX_W                = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 startOfFrame,
   input  logic signed [10:0]   pixelX,
   input  logic signed [10:0]   pixelY,
   input  logic signed [10:0]   ballTopLeftPosX [NUM_BALLS],
   input  logic signed [10:0]   ballTopLeftPosY [NUM_BALLS],
   input  logic [7:0]           ballColor [NUM_BALLS],
   input  logic [NUM_BALLS-1:0] sinkStart,
   input  logic [NUM_BALLS-1:0] spawn,
   output logic                 drawingRequestBall,
   output logic [7:0]           RGBoutBall,
   output logic [IDX_W-1:0]     ballHitIndex,
   output logic [NUM_BALLS-1:0] ballVisible,
   output logic [NUM_BALLS-1:0] sinkDone
);

   typedef enum logic [1:0] {
      ST_VISIBLE = 2'd0,
      ST_SINKING = 2'd1,
      ST_HIDDEN  = 2'd2
   } ball_state_e;

   localparam logic [3:0] LAST_CNT = 4'(SINK_RATE - 1);

   // Squared distance from the sprite centre, in half-pixel units: (2dx-31)^2 + (2dy-31)^2.
   function automatic logic [11:0] dist2(input logic [4:0] dx, input logic [4:0] dy);
      logic signed [11:0] u;
      logic signed [11:0] v;
      u = $signed({6'd0, dx, 1'b0}) - 12'sd31;
      v = $signed({6'd0, dy, 1'b0}) - 12'sd31;
      dist2 = 12'(u * u + v * v);
   endfunction

   function automatic logic [11:0] mask_limit(input logic [4:0] radius);
      logic [11:0] r;
      r = {7'd0, radius};
      mask_limit = (r * r) << 2'd2;
   endfunction

   // Bitmap: disc radius 16, outline ring from radius 14 outwards, number spot up-right.
   function automatic logic [1:0] rom_code(input logic [4:0] dx, input logic [4:0] dy);
      logic [11:0] d2;
      d2 = dist2(dx, dy);
      if (d2 > 12'd1024) begin
         rom_code = 2'd0;
      end else if (d2 > 12'd784) begin
         rom_code = 2'd2;
      end else if ((dx >= 5'd20) && (dx <= 5'd24) && (dy >= 5'd6) && (dy <= 5'd10)) begin
         rom_code = 2'd3;
      end else begin
         rom_code = 2'd1;
      end
   endfunction

   ball_state_e          state_r     [NUM_BALLS];
   ball_state_e          state_s     [NUM_BALLS];
   logic [4:0]           radius_r    [NUM_BALLS];
   logic [4:0]           radius_s    [NUM_BALLS];
   logic [3:0]           frame_cnt_r [NUM_BALLS];
   logic [3:0]           frame_cnt_s [NUM_BALLS];
   logic [NUM_BALLS-1:0] sink_done_s;
   logic [NUM_BALLS-1:0] sink_done_r;
   logic [NUM_BALLS-1:0] visible_s;
   logic [NUM_BALLS-1:0] hit_s;
   logic [NUM_BALLS-1:0] hit_r;
   logic [7:0]           col_s       [NUM_BALLS];
   logic [7:0]           col_r       [NUM_BALLS];
   logic [7:0]           rgb_s;
   logic [7:0]           rgb_r;
   logic [IDX_W-1:0]     idx_s;
   logic [IDX_W-1:0]     idx_r;

   // Per-ball state register: FSM state, radius and frame counter.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
         if (reset) begin
            state_r[i]     <= INIT_VISIBLE[i] ? ST_VISIBLE : ST_HIDDEN;
            radius_r[i]    <= 5'd16;
            frame_cnt_r[i] <= 4'd0;
         end else begin
            state_r[i]     <= state_s[i];
            radius_r[i]    <= radius_s[i];
            frame_cnt_r[i] <= frame_cnt_s[i];
         end
      end
   end

   // Per-ball next state; spawn overrides everything, radius only moves on frame pulses.
   always_comb begin
      for (int i = 0; i < NUM_BALLS; i++) begin
         state_s[i]     = state_r[i];
         radius_s[i]    = radius_r[i];
         frame_cnt_s[i] = frame_cnt_r[i];
         if (spawn[i]) begin
            state_s[i]     = ST_VISIBLE;
            radius_s[i]    = 5'd16;
            frame_cnt_s[i] = 4'd0;
         end else begin
            case (state_r[i])
               ST_VISIBLE: begin
                  if (sinkStart[i]) begin
                     state_s[i]     = ST_SINKING;
                     frame_cnt_s[i] = 4'd0;
                  end else begin
                     state_s[i] = ST_VISIBLE;
                  end
               end
               ST_SINKING: begin
                  if (startOfFrame && (frame_cnt_r[i] == LAST_CNT)) begin
                     frame_cnt_s[i] = 4'd0;
                     radius_s[i]    = radius_r[i] - 5'd1;
                     state_s[i]     = (radius_r[i] == 5'd1) ? ST_HIDDEN : ST_SINKING;
                  end else if (startOfFrame) begin
                     frame_cnt_s[i] = frame_cnt_r[i] + 4'd1;
                  end else begin
                     frame_cnt_s[i] = frame_cnt_r[i];
                  end
               end
               ST_HIDDEN: state_s[i] = ST_HIDDEN;
               default:   state_s[i] = ST_HIDDEN;
            endcase
         end
      end
   end

   // Per-ball outputs decoded from the state register and the pending transition.
   always_comb begin
      for (int i = 0; i < NUM_BALLS; i++) begin
         visible_s[i]   = (state_r[i] != ST_HIDDEN);
         sink_done_s[i] = (state_r[i] == ST_SINKING) && (state_s[i] == ST_HIDDEN);
      end
   end

   // Stage-1 hit test: 12-bit signed offsets so a ball near the screen edge never wraps.
   always_comb begin : hit_test
      logic signed [11:0] off_x;
      logic signed [11:0] off_y;
      logic [4:0]         dx;
      logic [4:0]         dy;
      logic [1:0]         code;
      logic               in_box;
      for (int i = 0; i < NUM_BALLS; i++) begin
         off_x  = {pixelX[10], pixelX} - {ballTopLeftPosX[i][10], ballTopLeftPosX[i]};
         off_y  = {pixelY[10], pixelY} - {ballTopLeftPosY[i][10], ballTopLeftPosY[i]};
         in_box = (off_x >= 12'sd0) && (off_x < 12'sd32) && (off_y >= 12'sd0) && (off_y < 12'sd32);
         dx     = off_x[4:0];
         dy     = off_y[4:0];
         code   = rom_code(dx, dy);
         case (code)
            2'd1:    col_s[i] = ballColor[i];
            2'd2:    col_s[i] = 8'h00;
            2'd3:    col_s[i] = 8'hFE;
            default: col_s[i] = TRANSPARENT_ENCODING;
         endcase
         hit_s[i] = (state_r[i] != ST_HIDDEN) && in_box && (code != 2'd0)
                    && (dist2(dx, dy) <= mask_limit(radius_r[i]))
                    && (col_s[i] != TRANSPARENT_ENCODING);
      end
   end

   // Stage-2 priority select: scanning downwards leaves the lowest hitting index.
   always_comb begin
      rgb_s = TRANSPARENT_ENCODING;
      idx_s = '0;
      for (int i = NUM_BALLS - 1; i >= 0; i--) begin
         rgb_s = hit_r[i] ? col_r[i] : rgb_s;
         idx_s = hit_r[i] ? IDX_W'(i) : idx_s;
      end
   end

   // Pipeline and pulse output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         hit_r       <= '0;
         rgb_r       <= TRANSPARENT_ENCODING;
         idx_r       <= '0;
         sink_done_r <= '0;
         for (int i = 0; i < NUM_BALLS; i++) begin
            col_r[i] <= TRANSPARENT_ENCODING;
         end
      end else begin
         hit_r       <= hit_s;
         rgb_r       <= rgb_s;
         idx_r       <= idx_s;
         sink_done_r <= sink_done_s;
         for (int i = 0; i < NUM_BALLS; i++) begin
            col_r[i] <= col_s[i];
         end
      end
   end

   assign RGBoutBall         = rgb_r;
   assign ballHitIndex       = idx_r;
   assign drawingRequestBall = (rgb_r != TRANSPARENT_ENCODING);
   assign ballVisible        = visible_s;
   assign sinkDone           = sink_done_r;

endmodule

// File: tb/tb_ball_multi_draw.sv
// Bench for ball_multi_draw: table vectors, hand sequences for sink/spawn/reset,
// and random traffic checked cycle by cycle against a behavioural model.
module tb_ball_multi_draw;
   localparam int              NB       = 2;
   localparam int              SR       = 2;
   localparam logic [7:0]      TR       = 8'hFF;
   localparam logic [NB-1:0]   INIT_VIS = '1;

   logic                clk = 1'b0;
   logic                reset;
   logic                startOfFrame;
   logic signed [10:0]  pixelX, pixelY;
   logic signed [10:0]  ballTopLeftPosX [NB];
   logic signed [10:0]  ballTopLeftPosY [NB];
   logic [7:0]          ballColor [NB];
   logic [NB-1:0]       sinkStart, spawn;
   logic                drawingRequestBall;
   logic [7:0]          RGBoutBall;
   logic [0:0]          ballHitIndex;
   logic [NB-1:0]       ballVisible, sinkDone;

   ball_multi_draw #(
      .NUM_BALLS(NB), .SINK_RATE(SR), .INIT_VISIBLE(INIT_VIS), .TRANSPARENT_ENCODING(TR)
   ) dut (
      .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
      .pixelX(pixelX), .pixelY(pixelY),
      .ballTopLeftPosX(ballTopLeftPosX), .ballTopLeftPosY(ballTopLeftPosY),
      .ballColor(ballColor), .sinkStart(sinkStart), .spawn(spawn),
      .drawingRequestBall(drawingRequestBall), .RGBoutBall(RGBoutBall),
      .ballHitIndex(ballHitIndex), .ballVisible(ballVisible), .sinkDone(sinkDone)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit m_vis  [NB];
   bit m_sink [NB];
   int m_frames [NB];
   int prev_rgb = TR;
   int prev_idx = 0;
   int done_cnt [NB];

   typedef struct {
      int px, py, x0, y0, x1, y1, c0, c1, rgb, idx;
   } vec_t;
   vec_t tbl [12];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int ref_color(input int dx, input int dy, input int body);
      int d2;
      d2 = (2*dx - 31) * (2*dx - 31) + (2*dy - 31) * (2*dy - 31);
      if (d2 > 1024) return TR;
      if (d2 > 784) return 8'h00;
      if (dx >= 20 && dx <= 24 && dy >= 6 && dy <= 10) return 8'hFE;
      return body;
   endfunction

   // Expected pixel for the current inputs and model state.
   function automatic void model_pix(output int rgb, output int idx);
      rgb = TR;
      idx = 0;
      for (int i = NB - 1; i >= 0; i--) begin
         int dx, dy, d2, r, c;
         dx = int'(pixelX) - int'(ballTopLeftPosX[i]);
         dy = int'(pixelY) - int'(ballTopLeftPosY[i]);
         r  = m_sink[i] ? 16 - m_frames[i] / SR : 16;
         if (m_vis[i] && dx >= 0 && dx < 32 && dy >= 0 && dy < 32) begin
            d2 = (2*dx - 31) * (2*dx - 31) + (2*dy - 31) * (2*dy - 31);
            c  = ref_color(dx, dy, int'(ballColor[i]));
            if (d2 <= 4 * r * r && c != TR) begin
               rgb = c;
               idx = i;
            end
         end
      end
   endfunction

   // One clock: predict, advance the model, then compare every output.
   task automatic step();
      int cur_rgb, cur_idx, exp_rgb, exp_idx;
      logic [NB-1:0] done_e, vis_e;
      model_pix(cur_rgb, cur_idx);
      done_e = '0;
      for (int i = 0; i < NB; i++) begin
         if (reset) begin
            m_vis[i] = INIT_VIS[i]; m_sink[i] = 1'b0; m_frames[i] = 0;
         end else if (spawn[i]) begin
            m_vis[i] = 1'b1; m_sink[i] = 1'b0; m_frames[i] = 0;
         end else if (m_vis[i] && !m_sink[i] && sinkStart[i]) begin
            m_sink[i] = 1'b1; m_frames[i] = 0;
         end else if (m_sink[i] && startOfFrame) begin
            m_frames[i]++;
            if (m_frames[i] == 16 * SR) begin
               m_vis[i] = 1'b0; m_sink[i] = 1'b0; done_e[i] = 1'b1;
            end
         end
         vis_e[i] = m_vis[i];
      end
      @(posedge clk);
      #1;
      if (reset) begin
         exp_rgb = TR; exp_idx = 0; prev_rgb = TR; prev_idx = 0;
      end else begin
         exp_rgb = prev_rgb; exp_idx = prev_idx; prev_rgb = cur_rgb; prev_idx = cur_idx;
      end
      chk("rgb", int'(RGBoutBall), exp_rgb);
      chk("drawreq", int'(drawingRequestBall), int'(exp_rgb != TR));
      chk("hitidx", int'(ballHitIndex), exp_idx);
      chk("visible", int'(ballVisible), int'(vis_e));
      chk("sinkdone", int'(sinkDone), int'(done_e));
      for (int i = 0; i < NB; i++) if (sinkDone[i]) done_cnt[i]++;
   endtask

   task automatic frame();
      startOfFrame = 1'b1;
      step();
      startOfFrame = 1'b0;
      step();
      step();
   endtask

   task automatic set_pix(input int x, input int y);
      pixelX = 11'(x);
      pixelY = 11'(y);
   endtask

   initial begin
      reset = 1'b1; startOfFrame = 1'b0; sinkStart = '0; spawn = '0;
      set_pix(0, 0);
      for (int i = 0; i < NB; i++) begin
         ballTopLeftPosX[i] = 11'(600); ballTopLeftPosY[i] = 11'(400); ballColor[i] = 8'h1C;
         done_cnt[i] = 0;
      end
      repeat (3) step();
      chk("reset_rgb", int'(RGBoutBall), 8'hFF);
      chk("reset_drawreq", int'(drawingRequestBall), 0);
      chk("reset_idx", int'(ballHitIndex), 0);
      chk("reset_visible", int'(ballVisible), int'(INIT_VIS));
      chk("reset_sinkdone", int'(sinkDone), 0);
      reset = 1'b0;

      //            px    py   x0   y0   x1   y1   c0     c1     rgb    idx
      tbl[0]  = '{116,  116, 100, 100, 600, 400, 'hC0, 'h1C, 'hC0, 0};
      tbl[1]  = '{132,  100, 100, 100, 600, 400, 'hC0, 'h1C, 'hFF, 0};
      tbl[2]  = '{216,   66, 200,  50, 200,  50, 'hC0, 'h1C, 'hC0, 0};
      tbl[3]  = '{  0,    0, -10, -10, 600, 400, 'hC0, 'h1C, 'hC0, 0};
      tbl[4]  = '{ -1,   -1,1020, 470, 600, 400, 'hC0, 'h1C, 'hFF, 0};
      tbl[5]  = '{116,  101, 100, 100, 600, 400, 'hC0, 'h1C, 'h00, 0};
      tbl[6]  = '{122,  108, 100, 100, 600, 400, 'hC0, 'h1C, 'hFE, 0};
      tbl[7]  = '{100,  100, 100, 100, 600, 400, 'hC0, 'h1C, 'hFF, 0};
      tbl[8]  = '{216,   66, 200,  50, 200,  50, 'hFF, 'h1C, 'h1C, 1};
      tbl[9]  = '{310,  215, 500, 300, 300, 200, 'hC0, 'h33, 'h33, 1};
      tbl[10] = '{131,  116, 100, 100, 600, 400, 'hC0, 'h1C, 'h00, 0};
      tbl[11] = '{132,  116, 100, 100, 600, 400, 'hC0, 'h1C, 'hFF, 0};
      for (int k = 0; k < 12; k++) begin
         set_pix(tbl[k].px, tbl[k].py);
         ballTopLeftPosX[0] = 11'(tbl[k].x0); ballTopLeftPosY[0] = 11'(tbl[k].y0);
         ballTopLeftPosX[1] = 11'(tbl[k].x1); ballTopLeftPosY[1] = 11'(tbl[k].y1);
         ballColor[0] = 8'(tbl[k].c0); ballColor[1] = 8'(tbl[k].c1);
         step();
         step();
         chk($sformatf("tbl%0d_rgb", k), int'(RGBoutBall), tbl[k].rgb);
         chk($sformatf("tbl%0d_idx", k), int'(ballHitIndex), tbl[k].idx);
         chk($sformatf("tbl%0d_drawreq", k), int'(drawingRequestBall), int'(tbl[k].rgb != 'hFF));
      end

      // Sink ball0 through 32 frame pulses.
      ballTopLeftPosX[0] = 11'(200); ballTopLeftPosY[0] = 11'(50); ballColor[0] = 8'hC0;
      ballTopLeftPosX[1] = 11'(600); ballTopLeftPosY[1] = 11'(400); ballColor[1] = 8'h1C;
      set_pix(216, 66);
      sinkStart[0] = 1'b1;
      step();
      sinkStart[0] = 1'b0;
      done_cnt[0] = 0;
      for (int f = 1; f <= 32; f++) begin
         startOfFrame = 1'b1;
         step();
         startOfFrame = 1'b0;
         chk("sinkdone_on_pulse", int'(sinkDone[0]), int'(f == 32));
         if (f == 16) begin
            set_pix(204, 54);
            step(); step();
            chk("r8_corner_transparent", int'(RGBoutBall), 8'hFF);
            set_pix(216, 66);
            step(); step();
            chk("r8_centre_draws", int'(RGBoutBall), 8'hC0);
         end
         step();
         step();
      end
      chk("sinkdone_once", done_cnt[0], 1);
      chk("ball0_hidden", int'(ballVisible[0]), 0);
      ballTopLeftPosX[1] = 11'(200); ballTopLeftPosY[1] = 11'(50);
      step(); step();
      chk("overlap_hidden_rgb", int'(RGBoutBall), 8'h1C);
      chk("overlap_hidden_idx", int'(ballHitIndex), 1);

      // Spawn beats a simultaneous sinkStart.
      spawn[1] = 1'b1; sinkStart[1] = 1'b1;
      step();
      spawn[1] = 1'b0; sinkStart[1] = 1'b0;
      done_cnt[1] = 0;
      repeat (40) frame();
      chk("spawn_wins_visible", int'(ballVisible[1]), 1);
      chk("spawn_wins_nodone", done_cnt[1], 0);
      set_pix(205, 55);
      step(); step();
      chk("spawn_wins_fullradius", int'(RGBoutBall), 8'h00);

      // Reset in the middle of a sink at radius 5.
      spawn[0] = 1'b1;
      step();
      spawn[0] = 1'b0;
      sinkStart[0] = 1'b1;
      step();
      sinkStart[0] = 1'b0;
      repeat (22) frame();
      set_pix(216, 66);
      step(); step();
      chk("r5_centre", int'(RGBoutBall), 8'hC0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midsink_reset_rgb", int'(RGBoutBall), 8'hFF);
      chk("midsink_reset_visible", int'(ballVisible), int'(INIT_VIS));
      set_pix(205, 55);
      step(); step();
      chk("after_reset_fullradius", int'(RGBoutBall), 8'h00);
      chk("after_reset_idx", int'(ballHitIndex), 0);

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 63) == 0) begin
            for (int i = 0; i < NB; i++) begin
               int bx, by;
               bx = ($urandom_range(0, 4) == 0) ? 1000 + int'($urandom_range(0, 23))
                                                : int'($urandom_range(0, 100)) - 20;
               by = int'($urandom_range(0, 100)) - 20;
               ballTopLeftPosX[i] = 11'(bx);
               ballTopLeftPosY[i] = 11'(by);
               ballColor[i] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            end
         end
         set_pix(int'($urandom_range(0, 140)) - 20, int'($urandom_range(0, 140)) - 20);
         startOfFrame = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < NB; i++) begin
            sinkStart[i] = ($urandom_range(0, 99) == 0);
            spawn[i]     = ($urandom_range(0, 299) == 0);
         end
         reset = ($urandom_range(0, 999) == 0);
         step();
      end
      reset = 1'b0; startOfFrame = 1'b0; sinkStart = '0; spawn = '0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
